// File: rtl/pulse_window_counter.sv
// Heartbeat pulse counter: synchronizes the sensor level, detects accepted beats and
// reports the beat count once per window. Define PULSE_DEBOUNCE_EN to build in the debounce filter.
`timescale 1ns/1ps
module pulse_window_counter #(
  parameter int unsigned WINDOW_CYCLES   = 15000000,
  parameter int unsigned DEBOUNCE_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_raw,
  input  logic       monitor_en,
  output logic [7:0] pulse_count,
  output logic       count_valid,
  output logic       pulse_edge,
  output logic       overflow,
  output logic       sensor_lost
);

  localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  // Returns {attempted increment past 255, saturated value}.
  function automatic logic [8:0] sat_inc8(input logic [7:0] v, input logic inc);
    if (!inc) begin
      return {1'b0, v};
    end
    if (v == 8'hFF) begin
      return {1'b1, v};
    end
    return {1'b0, v + 8'd1};
  endfunction

  logic sync1_q, sync2_q;
  logic filt_q, filt_d, filt_prev_q;
  logic rise;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [7:0]       acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [7:0]       pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             lost_q, lost_d;
  logic [7:0]       acc_inc;
  logic             ovf_inc;

  // Two-flop synchronizer for the asynchronous sensor level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pulse_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef PULSE_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [DEB_W-1:0] deb_q, deb_d;

  // The level flips only once the synchronized input has disagreed with it long enough
  always_comb begin
    filt_d = filt_q;
    deb_d  = '0;
    if (sync2_q != filt_q) begin
      if (deb_q == DEB_W'(DEBOUNCE_CYCLES)) begin
        filt_d = sync2_q;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q <= '0;
    end else begin
      deb_q <= deb_d;
    end
  end
`else
  assign filt_d = sync2_q;

  // Without the filter the debounce length has no effect on the logic.
  if (DEBOUNCE_CYCLES == 0) begin : g_deb_unused
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
    end
  end

  assign rise       = filt_q & ~filt_prev_q;
  assign pulse_edge = rise & (state_q != ST_IDLE);

  always_comb begin
    {ovf_inc, acc_inc} = sat_inc8(acc_q, pulse_edge);
    state_d   = state_q;
    win_d     = win_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    pc_d      = pc_q;
    ovf_d     = ovf_q;
    lost_d    = lost_q;

    if (!monitor_en) begin
      state_d   = ST_IDLE;
      win_d     = '0;
      acc_d     = '0;
      acc_ovf_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_COUNT;
          win_d     = '0;
          acc_d     = '0;
          acc_ovf_d = 1'b0;
        end
        ST_COUNT: begin
          acc_d     = acc_inc;
          acc_ovf_d = acc_ovf_q | ovf_inc;
          if (win_q == WIN_LAST) begin
            // A beat in the closing cycle still belongs to this window
            state_d = ST_REPORT;
            win_d   = '0;
            pc_d    = acc_inc;
            ovf_d   = acc_ovf_q | ovf_inc;
            lost_d  = (acc_inc == 8'd0);
          end else begin
            win_d = win_q + 1'b1;
          end
        end
        ST_REPORT: begin
          state_d   = ST_COUNT;
          win_d     = '0;
          acc_d     = {7'd0, pulse_edge};
          acc_ovf_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      pc_q      <= '0;
      ovf_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      pc_q      <= pc_d;
      ovf_q     <= ovf_d;
      lost_q    <= lost_d;
    end
  end

  assign count_valid = (state_q == ST_REPORT);
  assign pulse_count = pc_q;
  assign overflow    = ovf_q;
  assign sensor_lost = lost_q;

endmodule

// File: tb/tb_pulse_window_counter.sv
// Self-checking bench for pulse_window_counter: a window-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_pulse_window_counter;

  localparam int W  = 100;
  localparam int D  = 4;
  localparam int WB = 4000;
`ifdef PULSE_DEBOUNCE_EN
  localparam int EDGE_LAT    = 3 + D;
  localparam int GLITCH_ADDS = 0;
`else
  localparam int EDGE_LAT    = 3;
  localparam int GLITCH_ADDS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pulse_raw = 1'b0;
  logic       monitor_en = 1'b0;
  logic [7:0] pulse_count;
  logic       count_valid, pulse_edge, overflow, sensor_lost;

  logic       reset_b = 1'b0;
  logic       raw_b = 1'b0;
  logic       en_b = 1'b0;
  logic [7:0] pc_b;
  logic       cv_b, pe_b, ov_b, sl_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int last_v = 0, prev_v = 0, n_valid = 0;
  int last_edge = 0, n_edge = 0;

  always #5 clk = ~clk;

  pulse_window_counter #(.WINDOW_CYCLES(W), .DEBOUNCE_CYCLES(D)) u_dut (
    .clk(clk), .reset(reset), .pulse_raw(pulse_raw), .monitor_en(monitor_en),
    .pulse_count(pulse_count), .count_valid(count_valid), .pulse_edge(pulse_edge),
    .overflow(overflow), .sensor_lost(sensor_lost)
  );

  pulse_window_counter #(.WINDOW_CYCLES(WB), .DEBOUNCE_CYCLES(D)) u_big (
    .clk(clk), .reset(reset_b), .pulse_raw(raw_b), .monitor_en(en_b),
    .pulse_count(pc_b), .count_valid(cv_b), .pulse_edge(pe_b),
    .overflow(ov_b), .sensor_lost(sl_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: filtered level from raw-sample history, window phase from the
  // number of consecutive enabled cycles, beat count as an unbounded integer.
  bit rq[$];
  bit m_filt, m_nf, m_rise, m_same;
  int m_k, m_acc;
  bit e_edge, e_valid, e_ovf, e_lost;
  int e_count;

  task automatic model_clear();
    rq.delete();
    for (int i = 0; i < D + 3; i++) rq.push_back(1'b0);
    m_filt = 0; m_k = 0; m_acc = 0;
    e_edge = 0; e_valid = 0; e_ovf = 0; e_lost = 0; e_count = 0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        model_clear();
      end else begin
        rq.push_front(pulse_raw);
        void'(rq.pop_back());
`ifdef PULSE_DEBOUNCE_EN
        m_same = 1'b1;
        for (int i = 3; i <= D + 2; i++) if (rq[i] != rq[2]) m_same = 1'b0;
        m_nf = m_same ? rq[2] : m_filt;
`else
        m_nf = rq[2];
`endif
        m_rise = m_nf && !m_filt;
        m_filt = m_nf;
        if (monitor_en) m_k++; else m_k = 0;
        e_edge  = m_rise && (m_k > 0);
        e_valid = 1'b0;
        if (m_k > 0 && (m_k % (W + 1)) == 0) begin
          e_valid = 1'b1;
          e_count = (m_acc > 255) ? 255 : m_acc;
          e_ovf   = (m_acc > 255);
          e_lost  = (m_acc == 0);
          m_acc   = e_edge ? 1 : 0;
        end else if (m_k > 0) begin
          m_acc += e_edge ? 1 : 0;
        end else begin
          m_acc = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_pulse_count", pulse_count, e_count);
      check("model_count_valid", count_valid, e_valid);
      check("model_pulse_edge", pulse_edge, e_edge);
      check("model_overflow", overflow, e_ovf);
      check("model_sensor_lost", sensor_lost, e_lost);
      if (count_valid) begin
        prev_v = last_v;
        last_v = cyc;
        n_valid++;
      end
      if (pulse_edge) begin
        last_edge = cyc;
        n_edge++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulses(input bit sel, input int cnt, input int hi, input int lo);
    for (int i = 0; i < cnt; i++) begin
      if (sel) raw_b = 1'b1; else pulse_raw = 1'b1;
      step(hi);
      if (sel) raw_b = 1'b0; else pulse_raw = 1'b0;
      step(lo);
    end
  endtask

  task automatic wait_valid(input bit sel, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (sel ? cv_b : count_valid) seen = 1'b1;
    end
    check(name, seen, 1);
  endtask

  int c_en, c_g, c_p, c_re, c_rel, e_before, nv4;

  initial begin
    step(3);
    check("rst_pulse_count", pulse_count, 0);
    check("rst_count_valid", count_valid, 0);
    check("rst_pulse_edge", pulse_edge, 0);
    check("rst_overflow", overflow, 0);
    check("rst_sensor_lost", sensor_lost, 0);
    reset = 1'b1;
    reset_b = 1'b1;
    step(2);

    // Five 10/10 beats in the first window
    monitor_en = 1'b1;
    c_en = cyc;
    pulses(1'b0, 5, 10, 10);
    wait_valid(1'b0, 30, "w1_valid_seen");
    check("w1_first_report_delay", last_v - c_en, 101);
    check("w1_pulse_count", pulse_count, 5);
    check("w1_overflow", overflow, 0);
    check("w1_sensor_lost", sensor_lost, 0);
    step(1);
    check("w1_valid_single_cycle", count_valid, 0);

    // Silent window
    wait_valid(1'b0, 150, "w2_valid_seen");
    check("w2_pulse_count", pulse_count, 0);
    check("w2_sensor_lost", sensor_lost, 1);
    check("w2_overflow", overflow, 0);
    check("w2_period", last_v - prev_v, 101);

    // Two-cycle glitch, then one genuine beat
    step(1);
    e_before = n_edge;
    c_g = cyc;
    pulse_raw = 1'b1;
    step(2);
    pulse_raw = 1'b0;
    step(10);
    c_p = cyc;
    pulse_raw = 1'b1;
    step(10);
    pulse_raw = 1'b0;
    step(10);
    check("w3_edge_latency", last_edge - c_p, EDGE_LAT);
    check("w3_edge_total", n_edge - e_before, 1 + GLITCH_ADDS);
    wait_valid(1'b0, 150, "w3_valid_seen");
    check("w3_pulse_count", pulse_count, 1 + GLITCH_ADDS);
    check("w3_sensor_lost", sensor_lost, 0);
    check("w3_glitch_start_gap", c_p - c_g, 12);

    // Drop enable halfway through a window holding two beats
    step(1);
    nv4 = n_valid;
    pulses(1'b0, 2, 10, 10);
    step(9);
    monitor_en = 1'b0;
    step(20);
    check("w4_no_valid_while_dropped", n_valid - nv4, 0);
    check("w4_count_retained", pulse_count, 1 + GLITCH_ADDS);
    check("w4_lost_retained", sensor_lost, 0);
    monitor_en = 1'b1;
    c_re = cyc;
    pulses(1'b0, 3, 10, 10);
    wait_valid(1'b0, 60, "w4_reenable_valid_seen");
    check("w4_reenable_delay", last_v - c_re, 101);
    check("w4_pulse_count", pulse_count, 3);

    // Reset in the middle of a running window
    step(1);
    pulses(1'b0, 1, 10, 10);
    step(10);
    reset = 1'b0;
    #1;
    check("mid_rst_pulse_count", pulse_count, 0);
    check("mid_rst_count_valid", count_valid, 0);
    check("mid_rst_pulse_edge", pulse_edge, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_sensor_lost", sensor_lost, 0);
    step(2);
    reset = 1'b1;
    c_rel = cyc;
    pulses(1'b0, 4, 10, 10);
    wait_valid(1'b0, 40, "post_rst_valid_seen");
    check("post_rst_report_delay", last_v - c_rel, 101);
    check("post_rst_pulse_count", pulse_count, 4);
    check("post_rst_sensor_lost", sensor_lost, 0);
    monitor_en = 1'b0;

    // Long window: 300 beats saturate, then a quiet window of 3 beats
    step(1);
    en_b = 1'b1;
    pulses(1'b1, 300, 6, 6);
    wait_valid(1'b1, 600, "big1_valid_seen");
    check("big1_pulse_count", pc_b, 255);
    check("big1_overflow", ov_b, 1);
    check("big1_sensor_lost", sl_b, 0);
    step(1);
    pulses(1'b1, 3, 6, 6);
    wait_valid(1'b1, 4100, "big2_valid_seen");
    check("big2_pulse_count", pc_b, 3);
    check("big2_overflow", ov_b, 0);
    check("big2_sensor_lost", sl_b, 0);
    en_b = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
